arbitro_de_funcionalidade: RTL

Clocked arbiter that shares the LED-matrix/LED functionality outputs between the two user stations. It replaces the purely combinational priority/equality selection with sequenced grants: requests are validated, conflicts on the same functionality are resolved by user priority with round-robin on ties, and the winner keeps the resource for a bounded hold time. Its outputs drive the functionality decoders/multiplexers and the 7-segment user display.

---
 rtl/arbitro_pkg.sv | 29 ++
 rtl/arbitro_de_funcionalidade_contador.sv | 28 ++
 rtl/arbitro_de_funcionalidade.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the functionality arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arbitro_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      COOLDOWN = 2'd2
   } estado_t;

   localparam logic [2:0] USER_NENHUM = 3'b000;
   localparam logic [2:0] FUNC_NEUTRA = 3'b000;

   // Winning station index for a conflict on the same functionality:
   // higher user code wins; on a tie the station that did not win last time wins.
   function automatic logic maior_prioridade(input logic [2:0] a,
                                             input logic [2:0] b,
                                             input logic       ultimo);
      if (a > b) begin
         return 1'b0;
      end else if (b > a) begin
         return 1'b1;
      end else begin
         return ~ultimo;
      end
   endfunction

endpackage

// File: rtl/arbitro_de_funcionalidade_contador.sv
// Hold-time counter: counts RUN cycles and flags the last cycle of a grant.
// Latency: expiry flag is decoded from the registered count (same cycle).
// Backpressure: none; clear has priority over enable.
module contador_de_retencao #(
   parameter int HOLD_CYCLES = 1000,
   parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expira_o
);

   logic [CNT_W-1:0] count_q;

   // Count register: cleared by reset or clear, otherwise advances when enabled.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign expira_o = (count_q == CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/arbitro_de_funcionalidade.sv
// Arbiter sharing the LED/LED-matrix functionalities between two user stations.
// Latency: grants/denials one cycle after the request is sampled; all outputs registered.
// Backpressure: none; requests outside IDLE are ignored. Optional preemption: ARBITRO_PREEMPCAO_EN.
module arbitro_de_funcionalidade
   import arbitro_pkg::*;
#(
   parameter int HOLD_CYCLES = 1000
) (
   input  logic       Clock_i,
   input  logic       Reset_i,
   input  logic       Req0_i,
   input  logic       Req1_i,
   input  logic [2:0] User0_i,
   input  logic [2:0] User1_i,
   input  logic [2:0] Func0_i,
   input  logic [2:0] Func1_i,
   output logic       Grant0_o,
   output logic       Grant1_o,
   output logic [2:0] GrantFunc0_o,
   output logic [2:0] GrantFunc1_o,
   output logic [2:0] UserAtivo_o,
   output logic       Denied0_o,
   output logic       Denied1_o,
   output logic       Busy_o
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

   estado_t    state_q, state_d;
   logic       grant0_q, grant0_d;
   logic       grant1_q, grant1_d;
   logic [2:0] func0_q, func0_d;
   logic [2:0] func1_q, func1_d;
   logic [2:0] user0_q, user0_d;
   logic [2:0] user1_q, user1_d;
   logic       denied0_q, denied0_d;
   logic       denied1_q, denied1_d;
   logic       ultimo_q, ultimo_d;

   logic       vld0, vld1;
   logic       venc;
   logic       preempt;
   logic       cnt_clr, cnt_en, expira;

   assign vld0 = Req0_i & (User0_i != USER_NENHUM) & (Func0_i != FUNC_NEUTRA);
   assign vld1 = Req1_i & (User1_i != USER_NENHUM) & (Func1_i != FUNC_NEUTRA);

   contador_de_retencao #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W)
   ) u_contador (
      .clk_i    (Clock_i),
      .rst_i    (Reset_i),
      .clr_i    (cnt_clr),
      .en_i     (cnt_en),
      .expira_o (expira)
   );

   // State, grant, latch and pulse registers; reset drops everything without a denial.
   always_ff @(posedge Clock_i) begin
      if (Reset_i) begin
         state_q   <= IDLE;
         grant0_q  <= 1'b0;
         grant1_q  <= 1'b0;
         func0_q   <= FUNC_NEUTRA;
         func1_q   <= FUNC_NEUTRA;
         user0_q   <= USER_NENHUM;
         user1_q   <= USER_NENHUM;
         denied0_q <= 1'b0;
         denied1_q <= 1'b0;
         ultimo_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         grant0_q  <= grant0_d;
         grant1_q  <= grant1_d;
         func0_q   <= func0_d;
         func1_q   <= func1_d;
         user0_q   <= user0_d;
         user1_q   <= user1_d;
         denied0_q <= denied0_d;
         denied1_q <= denied1_d;
         ultimo_q  <= ultimo_d;
      end
   end

   // Next-state logic: request validation, conflict resolution, hold and release.
   always_comb begin
      state_d   = state_q;
      grant0_d  = grant0_q;
      grant1_d  = grant1_q;
      func0_d   = func0_q;
      func1_d   = func1_q;
      user0_d   = user0_q;
      user1_d   = user1_q;
      denied0_d = 1'b0;
      denied1_d = 1'b0;
      ultimo_d  = ultimo_q;
      venc      = 1'b0;
      preempt   = 1'b0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_clr   = 1'b1;
            grant0_d  = 1'b0;
            grant1_d  = 1'b0;
            // A raised but malformed request is refused straight away.
            denied0_d = Req0_i & ~vld0;
            denied1_d = Req1_i & ~vld1;
            if (vld0 && vld1) begin
               state_d = RUN;
               if (Func0_i != Func1_i) begin
                  grant0_d = 1'b1;
                  grant1_d = 1'b1;
                  func0_d  = Func0_i;
                  func1_d  = Func1_i;
                  user0_d  = User0_i;
                  user1_d  = User1_i;
               end else begin
                  venc     = maior_prioridade(User0_i, User1_i, ultimo_q);
                  ultimo_d = venc;
                  if (venc == 1'b0) begin
                     grant0_d  = 1'b1;
                     func0_d   = Func0_i;
                     user0_d   = User0_i;
                     denied1_d = 1'b1;
                  end else begin
                     grant1_d  = 1'b1;
                     func1_d   = Func1_i;
                     user1_d   = User1_i;
                     denied0_d = 1'b1;
                  end
               end
            end else if (vld0) begin
               state_d  = RUN;
               grant0_d = 1'b1;
               func0_d  = Func0_i;
               user0_d  = User0_i;
               ultimo_d = 1'b0;
            end else if (vld1) begin
               state_d  = RUN;
               grant1_d = 1'b1;
               func1_d  = Func1_i;
               user1_d  = User1_i;
               ultimo_d = 1'b1;
            end
         end

         RUN: begin
            cnt_en   = 1'b1;
            // An owner that lets go of its request loses the grant at once.
            grant0_d = grant0_q & Req0_i;
            grant1_d = grant1_q & Req1_i;
`ifdef ARBITRO_PREEMPCAO_EN
            // A sole owner is displaced by a strictly higher user on the same functionality.
            if (grant0_q && !grant1_q && vld1 &&
                (Func1_i == func0_q) && (User1_i > user0_q)) begin
               preempt   = 1'b1;
               grant0_d  = 1'b0;
               grant1_d  = 1'b1;
               func1_d   = Func1_i;
               user1_d   = User1_i;
               denied0_d = 1'b1;
               ultimo_d  = 1'b1;
               cnt_clr   = 1'b1;
            end else if (grant1_q && !grant0_q && vld0 &&
                         (Func0_i == func1_q) && (User0_i > user1_q)) begin
               preempt   = 1'b1;
               grant1_d  = 1'b0;
               grant0_d  = 1'b1;
               func0_d   = Func0_i;
               user0_d   = User0_i;
               denied1_d = 1'b1;
               ultimo_d  = 1'b0;
               cnt_clr   = 1'b1;
            end
`endif
            if (!preempt && (expira || !(grant0_d || grant1_d))) begin
               state_d  = COOLDOWN;
               grant0_d = 1'b0;
               grant1_d = 1'b0;
               cnt_clr  = 1'b1;
            end
         end

         COOLDOWN: begin
            cnt_clr  = 1'b1;
            grant0_d = 1'b0;
            grant1_d = 1'b0;
            state_d  = IDLE;
         end

         default: begin
            cnt_clr  = 1'b1;
            grant0_d = 1'b0;
            grant1_d = 1'b0;
            state_d  = IDLE;
         end
      endcase

      // Latched codes only live as long as their grant.
      if (!grant0_d) begin
         func0_d = FUNC_NEUTRA;
         user0_d = USER_NENHUM;
      end
      if (!grant1_d) begin
         func1_d = FUNC_NEUTRA;
         user1_d = USER_NENHUM;
      end
   end

   // Display code: the lower-priority of the active users, derived from registers only.
   always_comb begin
      UserAtivo_o = USER_NENHUM;
      if (grant0_q && grant1_q) begin
         UserAtivo_o = (user0_q < user1_q) ? user0_q : user1_q;
      end else if (grant0_q) begin
         UserAtivo_o = user0_q;
      end else if (grant1_q) begin
         UserAtivo_o = user1_q;
      end
   end

   assign Grant0_o     = grant0_q;
   assign Grant1_o     = grant1_q;
   assign GrantFunc0_o = func0_q;
   assign GrantFunc1_o = func1_q;
   assign Denied0_o    = denied0_q;
   assign Denied1_o    = denied1_q;
   assign Busy_o       = (state_q != IDLE);

endmodule
